// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO pop port between the UART receiver and the CPU-side register logic.
//   rx_data  : byte at the FIFO head, valid only while rx_valid is high
//   rx_valid : FIFO not empty
//   rx_ready : pop request; a pop happens when rx_valid && rx_ready
//   rx_count : current FIFO occupancy
// master = receiver (produces bytes), slave = consumer (pops bytes).
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [CountW-1:0] rx_count;

  modport master (output rx_data, output rx_valid, output rx_count, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO.
//   clk           : system clock, all logic on posedge
//   rst           : synchronous active-high reset
//   rxd_i         : asynchronous serial line, idles high
//   busy_o        : receive FSM not idle
//   framing_err_o : one-cycle pulse when the stop bit is sampled low
//   overrun_o     : one-cycle pulse when a good byte is dropped on a full FIFO
//   rx_if         : FIFO pop port (data/valid/ready/count)
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd_i,
  output logic           busy_o,
  output logic           framing_err_o,
  output logic           overrun_o,
  uart_rx_fifo_if.master rx_if
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  // Input synchronizer and edge detect
  logic rxd_meta_q, rxs_q, rxs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxs_q      <= rxd_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // FIFO: pointers carry an extra wrap bit to tell full from empty
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic          empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop   = !empty && rx_if.rx_ready;

  assign rx_if.rx_data  = mem_q[rd_ptr_q[PtrW-1:0]];
  assign rx_if.rx_valid = !empty;
  assign rx_if.rx_count = wr_ptr_q - rd_ptr_q;

  // Receive FSM
  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ferr_q, ferr_d, ovr_q, ovr_d;
  logic            expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= shift_q;
        wr_ptr_q                  <= wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = HalfM1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs_q) begin
          cnt_d   = FullM1;
          bit_d   = '0;
          state_d = StData;
        end else begin
          state_d = StIdle;  // false start, line went back high by mid-bit
        end
      end
      StData: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FullM1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      StStop: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs_q) begin
          // A pop in this same cycle frees a slot for the push
          if (!full || pop) push  = 1'b1;
          else              ovr_d = 1'b1;
          state_d = StIdle;
        end else begin
          ferr_d  = 1'b1;
          state_d = StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  assign framing_err_o = ferr_q;
  assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int unsigned ClksPerBit = 217;
  localparam int unsigned Depth      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic busy, framing_err, overrun;

  uart_rx_fifo_if #(.FIFO_DEPTH(Depth)) rx_if ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(ClksPerBit),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (rxd),
    .busy_o       (busy),
    .framing_err_o(framing_err),
    .overrun_o    (overrun),
    .rx_if        (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int max_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (ClksPerBit) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (ClksPerBit) tick();
    end
    rxd = stop;
    repeat (ClksPerBit) tick();
    rxd = 1'b1;
  endtask

  // Monitor: compares every pop against the scoreboard, counts error pulses
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h expected no byte", rx_if.rx_data);
          end else begin
            check("pop_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
          end
        end
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (int'(rx_if.rx_count) > max_cnt) max_cnt = int'(rx_if.rx_count);
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    rx_if.rx_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(rx_if.rx_valid), 0);
    check("reset_count", 32'(rx_if.rx_count), 0);
    check("reset_data", 32'(rx_if.rx_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ferr", 32'(framing_err), 0);
    check("reset_ovr", 32'(overrun), 0);
    repeat (20) tick();

    // 1: single byte, push latency, then a one-cycle pop
    fe0 = fe_cnt;
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1);
      begin
        // Start edge is seen 3 edges after rxd falls; stop sample at +108+9*217
        repeat (2064) @(negedge clk);
        check("t1_valid_before_stop", 32'(rx_if.rx_valid), 0);
        @(negedge clk);
        check("t1_valid_after_stop", 32'(rx_if.rx_valid), 1);
        check("t1_count", 32'(rx_if.rx_count), 1);
        check("t1_data", 32'(rx_if.rx_data), 32'h55);
      end
    join
    repeat (10) tick();
    check("t1_ferr", 32'(fe_cnt - fe0), 0);
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    check("t1_valid_after_pop", 32'(rx_if.rx_valid), 0);
    check("t1_count_after_pop", 32'(rx_if.rx_count), 0);

    // 2: 50-clock glitch is rejected at mid-bit
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    tick();
    rxd = 1'b0;
    repeat (50) tick();
    check("t2_busy_during", 32'(busy), 1);
    rxd = 1'b1;
    repeat (200) tick();
    check("t2_busy_after", 32'(busy), 0);
    check("t2_valid", 32'(rx_if.rx_valid), 0);
    check("t2_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

    // 3: bad stop bit followed by a long break, then a good byte
    fe0 = fe_cnt;
    send_byte(8'hA3, 1'b0);
    rxd = 1'b0;
    repeat (3000) tick();
    check("t3_busy_in_break", 32'(busy), 1);
    rxd = 1'b1;
    repeat (2 * ClksPerBit) tick();
    check("t3_ferr_once", 32'(fe_cnt - fe0), 1);
    check("t3_no_push", 32'(rx_if.rx_count), 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (10) tick();
    check("t3_data", 32'(rx_if.rx_data), 32'h3C);
    check("t3_ferr_total", 32'(fe_cnt - fe0), 1);
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    repeat (10) tick();

    // 4: overflow the FIFO, then drain it
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= int'(Depth)) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    repeat (10) tick();
    check("t4_count_full", 32'(rx_if.rx_count), 4);
    check("t4_overrun_once", 32'(ov_cnt - ov0), 1);
    check("t4_head", 32'(rx_if.rx_data), 32'h01);
    rx_if.rx_ready = 1'b1;
    repeat (6) tick();
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_drained", 32'(rx_if.rx_valid), 0);
    check("t4_sb_empty", 32'(exp_q.size()), 0);

    // 5: streaming with the consumer always ready
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    max_cnt = 0;
    rx_if.rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'hF0 + 8'(i));
      send_byte(8'hF0 + 8'(i), 1'b1);
    end
    repeat (10) tick();
    check("t5_sb_empty", 32'(exp_q.size()), 0);
    check("t5_max_count", 32'(max_cnt), 1);
    check("t5_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);
    rx_if.rx_ready = 1'b0;

    // 6: reset during data bit 4 of 0xF0 (line high from bit 4 on), then 0x7E
    rxd = 1'b0;
    repeat (ClksPerBit) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      repeat (ClksPerBit) tick();
    end
    rxd = 1'b1;
    repeat (100) tick();
    check("t6_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(busy), 0);
    repeat (5 * ClksPerBit) tick();
    check("t6_no_spurious", 32'(rx_if.rx_valid), 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (10) tick();
    check("t6_count", 32'(rx_if.rx_count), 1);
    check("t6_data", 32'(rx_if.rx_data), 32'h7E);
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    repeat (5) tick();
    check("final_sb_empty", 32'(exp_q.size()), 0);
    check("final_valid", 32'(rx_if.rx_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver peripheral for the SoC's RX pin: 8N1 framing, LSB first, fixed bit period in system clocks. It validates the start bit, samples each bit at mid-period, checks the stop bit, and pushes good bytes into a small FIFO. The CPU-side peripheral register logic drains the FIFO through a valid/ready pop port. Error conditions are reported as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 217, system clocks per UART bit (25 MHz / 115200); must be >= 8.
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
rxd  input  1  asynchronous serial line; idles high.
rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
rx_valid  output  1  FIFO not empty.
rx_ready  input  1  pop request; a pop occurs when rx_valid && rx_ready.
rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
busy  output  1  receive FSM is not in IDLE.
framing_err  output  1  one-cycle pulse when the stop bit is sampled 0.
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- rxd passes through a 2-flop synchronizer (reset value 1) into rxs. A prev register (reset 1) holds the last rxs value. A falling edge is rxs_prev=1 && rxs=0.
- Reset: FIFO empty, rx_valid=0, rx_count=0, rx_data=0, busy=0, framing_err=0, overrun=0, FSM=IDLE, bit counter=0, shift register=0. A reset mid-frame aborts the frame; no partial byte is ever pushed.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - Load the clock counter with CLKS_PER_BIT/2-1 on the falling-edge cycle E, then go to START.
- START:
  - Count down to 0, then sample rxs (cycle E+CLKS_PER_BIT/2).
  - rxs=0: reload the counter with CLKS_PER_BIT-1, bit index=0, go to DATA.
  - rxs=1: false start; return to IDLE with no flags raised.
- DATA:
  - Every counter expiry, shift rxs into the MSB of the shift register (LSB-first reception) and reload the counter.
  - After bit index 7, go to STOP.
  - Data bit k is sampled at cycle E+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
- STOP (sampled at E+CLKS_PER_BIT/2+9*CLKS_PER_BIT):
  - rxs=1 and FIFO not full (after this cycle's pop): push the shift register, go to IDLE.
  - rxs=1 and FIFO still full: drop the byte, pulse overrun, go to IDLE.
  - rxs=0: pulse framing_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. A break condition therefore produces exactly one framing_err.
- busy=1 in every state except IDLE.
- FIFO:
  - Circular buffer; read/write pointers have one extra wrap bit.
  - rx_data is driven directly from mem[rd_ptr].
  - A push becomes visible the cycle after the stop sample: rx_valid=1, rx_count incremented.
  - Simultaneous push and pop: both occur and rx_count is unchanged. When full, the simultaneous pop frees the slot, so the push is accepted and no overrun is raised.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- The FSM returns to IDLE before the stop bit ends, so back-to-back frames with one stop bit are received without loss.

Test Plan:
- Send 0x55 on rxd at 217 clks/bit with rx_ready=0 -> rx_valid=1 one cycle after the stop sample, rx_data=0x55, rx_count=1, framing_err=0. Then pulse rx_ready for one cycle -> rx_valid=0, rx_count=0.
- Drive rxd low for 50 clocks, then high -> start rejected at mid-bit, busy returns to 0, rx_valid stays 0, no error pulses.
- Send 0xA3 with stop bit=0, then hold rxd low for 3000 clocks, then send 0x3C normally -> exactly one framing_err pulse, no push for 0xA3, then rx_data=0x3C.
- Send 0x01..0x05 back-to-back with rx_ready=0 (FIFO_DEPTH=4) -> rx_count=4, overrun pulses once at the 5th stop sample. Popping returns 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
- Send 8 back-to-back bytes 0xF0..0xF7 with rx_ready=1 -> all 8 popped in order, rx_count never exceeds 1, no overrun or framing_err.
- Assert rst for one cycle during data bit 4 of a frame, then send 0x7E -> no spurious byte, busy=0 after reset, rx_data=0x7E received correctly.
